// File: rtl/tank_pkg.sv
// tank_pkg: shared definitions for the tank bullet logic.
//   DEF_NUM_SLOTS        bullet instances owned by one tank
//   DEF_COOLDOWN_FRAMES  minimum frames between launches
//   DEF_ACK_TIMEOUT      frames to wait for a slot to report active
//   bullet_ctrl_state_t  launch controller states
//   clog2_min1           counter/index width helper that never returns 0
package tank_pkg;

   localparam int unsigned DEF_NUM_SLOTS       = 5;
   localparam int unsigned DEF_COOLDOWN_FRAMES = 12;
   localparam int unsigned DEF_ACK_TIMEOUT     = 3;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LAUNCH   = 2'd1,
      COOLDOWN = 2'd2
   } bullet_ctrl_state_t;

   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v <= 1) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/lowest_free_enc.sv
// lowest_free_enc: combinational priority encoder returning the lowest-index
// slot whose active flag is 0.
//   slot_active_i  per-slot active flags
//   idx_o          index of lowest inactive slot (0 when none)
//   found_o        1 when at least one slot is inactive
module lowest_free_enc
   import tank_pkg::*;
#(
   parameter int unsigned N  = DEF_NUM_SLOTS,
   parameter int unsigned IW = clog2_min1(DEF_NUM_SLOTS)
) (
   input  logic [N-1:0]  slot_active_i,
   output logic [IW-1:0] idx_o,
   output logic          found_o
);

   // Scan from the top down so the lowest free index is written last and wins.
   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      for (int unsigned i = N; i > 0; i--) begin
         if (!slot_active_i[i-1]) begin
            idx_o   = IW'(i - 1);
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bullet_pool_ctrl.sv
// bullet_pool_ctrl: turns fire key presses into one-hot create requests for a
// tank's bullet pool, waits for the chosen slot to go active, then enforces a
// cooldown before the next launch.
//   frame_clk    frame clock (rising edge)
//   Reset        asynchronous active-high reset
//   enable       game running; low forces IDLE
//   fire         fire key level
//   slot_active  per-slot is_bullet_active
//   create       one-hot create request, held through LAUNCH
//   launch_ok    one-frame pulse, slot confirmed active
//   launch_drop  one-frame pulse, no free slot or activation timeout
//   free_count   number of inactive slots (saturating at 7)
//   busy         state is not IDLE
module bullet_pool_ctrl
   import tank_pkg::*;
#(
   parameter int unsigned NUM_SLOTS       = DEF_NUM_SLOTS,
   parameter int unsigned COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
   parameter int unsigned ACK_TIMEOUT     = DEF_ACK_TIMEOUT
) (
   input  logic                 frame_clk,
   input  logic                 Reset,
   input  logic                 enable,
   input  logic                 fire,
   input  logic [NUM_SLOTS-1:0] slot_active,
   output logic [NUM_SLOTS-1:0] create,
   output logic                 launch_ok,
   output logic                 launch_drop,
   output logic [2:0]           free_count,
   output logic                 busy
);

   localparam int unsigned SEL_W = clog2_min1(NUM_SLOTS);
   localparam int unsigned CD_W  = clog2_min1(COOLDOWN_FRAMES);
   localparam int unsigned TO_W  = clog2_min1(ACK_TIMEOUT);

   localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES - 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

   bullet_ctrl_state_t   state_q, state_d;
   logic                 fire_q;
   logic                 armed_q, armed_d;
   logic [SEL_W-1:0]     sel_q, sel_d;
   logic [NUM_SLOTS-1:0] create_q, create_d;
   logic                 ok_q, ok_d;
   logic                 drop_q, drop_d;
   logic [CD_W-1:0]      cd_q, cd_d;
   logic [TO_W-1:0]      to_q, to_d;

   logic                 fire_edge;
   logic [SEL_W-1:0]     free_idx;
   logic                 free_found;
   int unsigned          n_free;

   lowest_free_enc #(
      .N  (NUM_SLOTS),
      .IW (SEL_W)
   ) u_enc (
      .slot_active_i (slot_active),
      .idx_o         (free_idx),
      .found_o       (free_found)
   );

   // armed_q is low only for the first frame after reset; fire_q still samples
   // fire then, so a key already held at release cannot produce an edge.
   assign fire_edge = fire & ~fire_q & armed_q;

   always_comb begin
      state_d  = state_q;
      armed_d  = 1'b1;
      sel_d    = sel_q;
      create_d = create_q;
      ok_d     = 1'b0;
      drop_d   = 1'b0;
      cd_d     = cd_q;
      to_d     = to_q;

      if (!enable) begin
         state_d  = IDLE;
         create_d = '0;
         cd_d     = '0;
         to_d     = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (fire_edge) begin
                  if (free_found) begin
                     sel_d    = free_idx;
                     create_d = NUM_SLOTS'(1) << free_idx;
                     to_d     = '0;
                     state_d  = LAUNCH;
                  end else begin
                     drop_d = 1'b1;
                  end
               end
            end
            LAUNCH: begin
               if (slot_active[sel_q]) begin
                  ok_d     = 1'b1;
                  create_d = '0;
                  cd_d     = CD_LOAD;
                  state_d  = COOLDOWN;
               end else if (to_q == TO_LAST) begin
                  drop_d   = 1'b1;
                  create_d = '0;
                  cd_d     = CD_LOAD;
                  state_d  = COOLDOWN;
               end else begin
                  to_d = to_q + 1'b1;
               end
            end
            COOLDOWN: begin
               if (cd_q == '0) begin
                  state_d = IDLE;
               end else begin
                  cd_d = cd_q - 1'b1;
               end
            end
            default: begin
               state_d  = IDLE;
               create_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= IDLE;
         fire_q   <= 1'b0;
         armed_q  <= 1'b0;
         sel_q    <= '0;
         create_q <= '0;
         ok_q     <= 1'b0;
         drop_q   <= 1'b0;
         cd_q     <= '0;
         to_q     <= '0;
      end else begin
         state_q  <= state_d;
         fire_q   <= fire;
         armed_q  <= armed_d;
         sel_q    <= sel_d;
         create_q <= create_d;
         ok_q     <= ok_d;
         drop_q   <= drop_d;
         cd_q     <= cd_d;
         to_q     <= to_d;
      end
   end

   always_comb begin
      n_free = 0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         if (!slot_active[i]) n_free = n_free + 1;
      end
      free_count = (n_free > 7) ? 3'd7 : 3'(n_free);
   end

   assign create      = create_q;
   assign launch_ok   = ok_q;
   assign launch_drop = drop_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: doc/bullet_pool_ctrl.md
BULLET_POOL_CTRL -- requirements
Module: bullet_pool_ctrl

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 5, meaning the number of bullet instances owned by one tank.
REQ-002 SHALL have parameter COOLDOWN_FRAMES, default 12, meaning the minimum number of frames between launches.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 3, meaning the number of frames to wait for slot activation.
REQ-004 SHALL have port frame_clk, input, 1, the clock; the design is clocked on its rising edge.
REQ-005 SHALL have port Reset, input, 1, an asynchronous active-high reset.
REQ-006 SHALL have port enable, input, 1, meaning the game is running.
REQ-007 SHALL have port fire, input, 1, the fire key level decoded from the keycode.
REQ-008 SHALL have port slot_active, input, NUM_SLOTS, carrying each bullet's is_bullet_active.
REQ-009 SHALL have port create, output, NUM_SLOTS, a one-hot create request to the bullet slots.
REQ-010 SHALL have port launch_ok, output, 1, a one-frame pulse when a launch is confirmed.
REQ-011 SHALL have port launch_drop, output, 1, a one-frame pulse when a shot is refused or times out.
REQ-012 SHALL have port free_count, output, 3, giving the number of inactive slots.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-014 SHALL register fire into fire_q and define fire_edge = fire & ~fire_q; holding fire SHALL yield only one shot.
REQ-015 SHALL implement an FSM with states IDLE, LAUNCH and COOLDOWN.
REQ-016 IDLE: on fire_edge & enable with at least one free slot, SHALL latch sel = the lowest-index slot with slot_active=0, then go to LAUNCH.
REQ-017 IDLE: on fire_edge & enable with no free slot, SHALL pulse launch_drop for one frame and stay in IDLE.
REQ-018 LAUNCH: SHALL hold create[sel]=1 and all other create bits 0 for the whole state.
  - The bullet takes 2 frames from create to active, so create must be held until activation.
REQ-019 LAUNCH: when slot_active[sel]=1, SHALL pulse launch_ok, drop create, load the cooldown counter with COOLDOWN_FRAMES-1, and go to COOLDOWN.
REQ-020 LAUNCH: after ACK_TIMEOUT frames without slot_active[sel], SHALL pulse launch_drop, drop create, load the cooldown counter, and go to COOLDOWN.
REQ-021 COOLDOWN: SHALL decrement the counter each frame and go to IDLE when it reaches 0.
  - Launch-to-launch spacing is at least COOLDOWN_FRAMES+1 frames.
REQ-022 SHALL ignore, and not queue, any fire_edge occurring in LAUNCH or COOLDOWN.
REQ-023 enable=0 in any state SHALL force IDLE on the next edge, zero create, and leave fire_q tracking.
REQ-024 SHALL derive free_count combinationally as the popcount of ~slot_active, saturating at 7.
REQ-025 A slot other than sel changing state during LAUNCH SHALL not affect sel or create.
REQ-026 launch_ok and launch_drop SHALL never be high in the same frame.
REQ-027 create SHALL be one-hot or all zero at all times.

Reset
REQ-028 Reset=1 SHALL asynchronously force:
  - state=IDLE, create=0, launch_ok=0, launch_drop=0;
  - the cooldown and timeout counters to 0, sel=0, fire_q=0.
REQ-029 Reset asserted mid-LAUNCH SHALL remove create in the same cycle, with no frame-edge wait.
REQ-030 After Reset release, fire already held high SHALL not fire until it is released and pressed again.
  - fire_q reset to 0 would otherwise generate an edge on the first frame, so fire_q SHALL instead load fire during the first post-reset frame, with fire_edge masked for that frame.

Structure
REQ-031 Shared package tank_pkg SHALL hold:
  - NUM_SLOTS, COOLDOWN_FRAMES and ACK_TIMEOUT defaults;
  - the enum type bullet_ctrl_state_t {IDLE, LAUNCH, COOLDOWN}.
REQ-032 One sub-module, lowest_free_enc, SHALL provide combinational lowest-zero priority encoding of slot_active, outputting an index and a found flag.
REQ-033 Everything else SHALL stay in bullet_pool_ctrl as a single always_ff plus combinational next-state and output logic.

Verification
REQ-034 Reset, slot_active=00000, fire 0->1 and held -> create=00001 for 2 frames, then slot_active[0]=1 -> launch_ok pulse, COOLDOWN, no second shot while fire is held.
REQ-035 slot_active=11011, fire edge -> create=00100; slot_active=11111, fire edge -> launch_drop pulse, create stays 0, state stays IDLE.
REQ-036 Fire edge, slot never activates -> create high exactly 3 frames, then launch_drop and COOLDOWN for 12 frames.
REQ-037 Fire edges at frames 0, 5 and 15 with COOLDOWN_FRAMES=12 and ack at 2 frames -> a launch at 0, frame 5 ignored, a launch at 15.
REQ-038 Reset pulsed mid-LAUNCH -> create=0 immediately; fire held across reset release -> no shot until release and re-press.
REQ-039 enable dropped during COOLDOWN -> IDLE next frame; free_count tracks popcount in every scenario.
